// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding, instruction
// size and the default boot address.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      RUN      = 2'd1,
      WAIT_MEM = 2'd2
   } pc_seq_state_t;

   localparam int unsigned INSTR_BYTES = 4;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_redirect_latch.sv
// Holds a redirect that could not be applied because instruction memory was
// stalled. A new set always wins over a clear, so the youngest redirect seen
// while waiting is the one that is eventually taken.
module pc_redirect_latch
   import pc_seq_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            Reset,
   input  logic            set,
   input  logic            clear,
   input  logic [XLEN-1:0] set_target,
   output logic            pend,
   output logic [XLEN-1:0] pend_target
);

   logic            pend_reg;
   logic [XLEN-1:0] target_reg;

   // Pending flag and target: reset clears, set overwrites, clear drops.
   always_ff @(posedge clk) begin
      if (Reset) begin
         pend_reg   <= 1'b0;
         target_reg <= '0;
      end else if (set) begin
         pend_reg   <= 1'b1;
         target_reg <= set_target;
      end else if (clear) begin
         pend_reg   <= 1'b0;
      end
   end

   assign pend        = pend_reg;
   assign pend_target = target_reg;

endmodule

// File: rtl/pc_sequencer.sv
// PC / IF-ID sequencer: chooses the next PC and the IF/ID enable and flush,
// arbitrating boot hold, redirects, load-use stalls and imem wait states.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter int              BOOT_CYCLES  = 2
) (
   input  logic            clk,
   input  logic            Reset,
   input  logic [XLEN-1:0] pc_cur,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   input  logic            jump,
   input  logic [XLEN-1:0] jump_target,
   input  logic            load_use_stall,
   input  logic            imem_ready,
   output logic [XLEN-1:0] pc_next,
   output logic            pc_le,
   output logic            ifid_le,
   output logic            ifid_flush,
   output logic            fetch_valid,
   output logic [1:0]      state
);

   localparam int CW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

   pc_seq_state_t   state_reg, state_next;
   logic [CW-1:0]   cnt_reg, cnt_next;

   logic            redirect;
   logic [XLEN-1:0] redirect_target;
   logic [XLEN-1:0] pc_seq;
   logic            latch_set;
   logic            latch_clear;
   logic            pend;
   logic [XLEN-1:0] pend_target;

   // EX-stage branch is older than the ID-stage jump, so it takes precedence.
   assign redirect        = branch_taken | jump;
   assign redirect_target = branch_taken ? branch_target : jump_target;
   assign pc_seq          = pc_cur + XLEN'(INSTR_BYTES);

   pc_redirect_latch #(
      .XLEN (XLEN)
   ) u_redirect_latch (
      .clk         (clk),
      .Reset       (Reset),
      .set         (latch_set),
      .clear       (latch_clear),
      .set_target  (redirect_target),
      .pend        (pend),
      .pend_target (pend_target)
   );

   // State and boot counter registers.
   always_ff @(posedge clk) begin
      if (Reset) begin
         state_reg <= BOOT;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Next-state and output decode from registered state plus current inputs.
   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      pc_next     = pc_seq;
      pc_le       = 1'b0;
      ifid_le     = 1'b0;
      ifid_flush  = 1'b0;
      fetch_valid = 1'b0;
      latch_set   = 1'b0;
      latch_clear = 1'b0;
      case (state_reg)
         BOOT: begin
            // Keep loading the boot address; all redirects and stalls ignored.
            pc_next    = RESET_VECTOR;
            pc_le      = 1'b1;
            ifid_flush = 1'b1;
            if (cnt_reg == CW'(BOOT_CYCLES - 1)) begin
               state_next = RUN;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         RUN: begin
            if (redirect) begin
               pc_next    = redirect_target;
               ifid_le    = 1'b1;
               ifid_flush = 1'b1;
               if (imem_ready) begin
                  pc_le = 1'b1;
               end else begin
                  latch_set  = 1'b1;
                  state_next = WAIT_MEM;
               end
            end else if (load_use_stall) begin
               // Freeze PC and IF/ID; all enables already low.
            end else if (!imem_ready) begin
               ifid_le    = 1'b1;
               ifid_flush = 1'b1;
               state_next = WAIT_MEM;
            end else begin
               pc_le       = 1'b1;
               ifid_le     = 1'b1;
               fetch_valid = 1'b1;
            end
         end
         WAIT_MEM: begin
            ifid_le    = 1'b1;
            ifid_flush = 1'b1;
            if (!imem_ready) begin
               if (redirect) begin
                  pc_next   = redirect_target;
                  latch_set = 1'b1;
               end else if (pend) begin
                  pc_next = pend_target;
               end
            end else begin
               state_next  = RUN;
               latch_clear = 1'b1;
               if (redirect) begin
                  pc_next = redirect_target;
                  pc_le   = 1'b1;
               end else if (pend) begin
                  pc_next = pend_target;
                  pc_le   = 1'b1;
               end else if (load_use_stall) begin
                  ifid_le    = 1'b0;
                  ifid_flush = 1'b0;
               end else begin
                  ifid_flush  = 1'b0;
                  pc_le       = 1'b1;
                  fetch_valid = 1'b1;
               end
            end
         end
         default: begin
            // Unused encoding: recover through boot.
            pc_next    = RESET_VECTOR;
            pc_le      = 1'b1;
            ifid_flush = 1'b1;
            state_next = BOOT;
            cnt_next   = '0;
         end
      endcase
   end

   assign state = state_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scenario bench for pc_sequencer: each cycle pushes the expected outputs to a
// queue when stimulus is applied and pops/compares them before the next edge.
module tb_pc_sequencer;

   logic        clk;
   logic        Reset;
   logic [31:0] pc_cur;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic        load_use_stall;
   logic        imem_ready;
   logic [31:0] pc_next;
   logic        pc_le;
   logic        ifid_le;
   logic        ifid_flush;
   logic        fetch_valid;
   logic [1:0]  state;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [37:0] exp;
      logic [37:0] mask;
      string       name;
   } exp_t;

   exp_t sb[$];

   localparam logic [37:0] MA = {38{1'b1}};
   localparam logic [37:0] MN = {32'h0, 6'h3F};

   pc_sequencer #(
      .XLEN         (32),
      .RESET_VECTOR (32'h0000_0000),
      .BOOT_CYCLES  (2)
   ) dut (
      .clk            (clk),
      .Reset          (Reset),
      .pc_cur         (pc_cur),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .jump           (jump),
      .jump_target    (jump_target),
      .load_use_stall (load_use_stall),
      .imem_ready     (imem_ready),
      .pc_next        (pc_next),
      .pc_le          (pc_le),
      .ifid_le        (ifid_le),
      .ifid_flush     (ifid_flush),
      .fetch_valid    (fetch_valid),
      .state          (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [37:0] pk(logic [31:0] pc, logic le, logic il,
                                      logic fl, logic fv, logic [1:0] st);
      return {pc, le, il, fl, fv, st};
   endfunction

   task automatic set_in(logic rst, logic [31:0] pc, logic br, logic [31:0] bt,
                         logic j, logic [31:0] jt, logic stall, logic rdy);
      Reset          = rst;
      pc_cur         = pc;
      branch_taken   = br;
      branch_target  = bt;
      jump           = j;
      jump_target    = jt;
      load_use_stall = stall;
      imem_ready     = rdy;
   endtask

   // Drive one cycle of stimulus just after the edge and queue its expectation.
   task automatic drv(logic rst, logic [31:0] pc, logic br, logic [31:0] bt,
                      logic j, logic [31:0] jt, logic stall, logic rdy,
                      logic [37:0] e, logic [37:0] m, string nm);
      exp_t x;
      @(posedge clk);
      #1;
      set_in(rst, pc, br, bt, j, jt, stall, rdy);
      x.exp  = e;
      x.mask = m;
      x.name = nm;
      sb.push_back(x);
   endtask

   task automatic test_reset();
      exp_t e;
      logic [37:0] obs;
      for (int i = 0; i < 8; i++) begin
         case (i)
            0, 1:    drv(1, 0, 0, 0, 0, 0, 0, 1, pk(32'h0, 1, 0, 1, 0, 0), MA, "reset_hold");
            2, 3:    drv(0, 0, 0, 0, 0, 0, 0, 1, pk(32'h0, 1, 0, 1, 0, 0), MA, "boot");
            4:       drv(0, 32'h0, 0, 0, 0, 0, 0, 1, pk(32'h4, 1, 1, 0, 1, 1), MA, "seq0");
            5:       drv(0, 32'h4, 0, 0, 0, 0, 0, 1, pk(32'h8, 1, 1, 0, 1, 1), MA, "seq1");
            default: drv(0, 32'h8, 0, 0, 0, 0, 0, 1, pk(32'hC, 1, 1, 0, 1, 1), MA, "seq2");
         endcase
         @(negedge clk);
         e   = sb.pop_front();
         obs = {pc_next, pc_le, ifid_le, ifid_flush, fetch_valid, state};
         total++;
         if ((obs & e.mask) !== (e.exp & e.mask)) begin
            bad++;
            $display("FAIL %s cyc%0d: got=%h want=%h", e.name, i, obs & e.mask, e.exp & e.mask);
         end else $display("ok %s cyc%0d: outputs=%h", e.name, i, obs);
      end
   endtask

   task automatic test_load_use();
      exp_t e;
      logic [37:0] obs;
      for (int i = 0; i < 3; i++) begin
         if (i < 2) drv(0, 32'h40, 0, 0, 0, 0, 1, 1, pk(32'h0, 0, 0, 0, 0, 1), MN, "load_use_hold");
         else       drv(0, 32'h40, 0, 0, 0, 0, 0, 1, pk(32'h44, 1, 1, 0, 1, 1), MA, "load_use_release");
         @(negedge clk);
         e   = sb.pop_front();
         obs = {pc_next, pc_le, ifid_le, ifid_flush, fetch_valid, state};
         total++;
         if ((obs & e.mask) !== (e.exp & e.mask)) begin
            bad++;
            $display("FAIL %s cyc%0d: got=%h want=%h", e.name, i, obs & e.mask, e.exp & e.mask);
         end else $display("ok %s cyc%0d: outputs=%h", e.name, i, obs);
      end
   endtask

   task automatic test_redirect_priority();
      exp_t e;
      logic [37:0] obs;
      for (int i = 0; i < 2; i++) begin
         if (i == 0) drv(0, 32'h44, 1, 32'h100, 1, 32'h200, 1, 1, pk(32'h100, 1, 1, 1, 0, 1), MA, "branch_over_jump_stall");
         else        drv(0, 32'h100, 0, 32'h0, 1, 32'h200, 1, 1, pk(32'h200, 1, 1, 1, 0, 1), MA, "jump_over_stall");
         @(negedge clk);
         e   = sb.pop_front();
         obs = {pc_next, pc_le, ifid_le, ifid_flush, fetch_valid, state};
         total++;
         if ((obs & e.mask) !== (e.exp & e.mask)) begin
            bad++;
            $display("FAIL %s cyc%0d: got=%h want=%h", e.name, i, obs & e.mask, e.exp & e.mask);
         end else $display("ok %s cyc%0d: outputs=%h", e.name, i, obs);
      end
   endtask

   task automatic test_wait_branch();
      exp_t e;
      logic [37:0] obs;
      for (int i = 0; i < 6; i++) begin
         case (i)
            0:       drv(0, 32'h200, 1, 32'h80, 0, 0, 0, 0, pk(32'h80, 0, 1, 1, 0, 1), MA, "branch_mem_busy");
            1, 2, 3: drv(0, 32'h200, 0, 0, 0, 0, 0, 0, pk(32'h0, 0, 1, 1, 0, 2), MN, "wait_mem");
            4:       drv(0, 32'h200, 0, 0, 0, 0, 0, 1, pk(32'h80, 1, 1, 1, 0, 2), MA, "pend_apply");
            default: drv(0, 32'h80, 0, 0, 0, 0, 0, 1, pk(32'h84, 1, 1, 0, 1, 1), MA, "after_pend");
         endcase
         @(negedge clk);
         e   = sb.pop_front();
         obs = {pc_next, pc_le, ifid_le, ifid_flush, fetch_valid, state};
         total++;
         if ((obs & e.mask) !== (e.exp & e.mask)) begin
            bad++;
            $display("FAIL %s cyc%0d: got=%h want=%h", e.name, i, obs & e.mask, e.exp & e.mask);
         end else $display("ok %s cyc%0d: outputs=%h", e.name, i, obs);
      end
   endtask

   task automatic test_wait_overwrite();
      exp_t e;
      logic [37:0] obs;
      for (int i = 0; i < 6; i++) begin
         case (i)
            0:       drv(0, 32'h84, 0, 0, 0, 0, 0, 0, pk(32'h0, 0, 1, 1, 0, 1), MN, "mem_busy_bubble");
            1:       drv(0, 32'h84, 0, 0, 1, 32'h300, 0, 0, pk(32'h0, 0, 1, 1, 0, 2), MN, "wait_jump");
            2:       drv(0, 32'h84, 0, 0, 0, 0, 0, 0, pk(32'h0, 0, 1, 1, 0, 2), MN, "wait_idle");
            3:       drv(0, 32'h84, 1, 32'h500, 0, 0, 0, 0, pk(32'h0, 0, 1, 1, 0, 2), MN, "wait_branch");
            4:       drv(0, 32'h84, 0, 0, 0, 0, 0, 1, pk(32'h500, 1, 1, 1, 0, 2), MA, "overwrite_apply");
            default: drv(0, 32'h500, 0, 0, 0, 0, 0, 1, pk(32'h504, 1, 1, 0, 1, 1), MA, "after_overwrite");
         endcase
         @(negedge clk);
         e   = sb.pop_front();
         obs = {pc_next, pc_le, ifid_le, ifid_flush, fetch_valid, state};
         total++;
         if ((obs & e.mask) !== (e.exp & e.mask)) begin
            bad++;
            $display("FAIL %s cyc%0d: got=%h want=%h", e.name, i, obs & e.mask, e.exp & e.mask);
         end else $display("ok %s cyc%0d: outputs=%h", e.name, i, obs);
      end
   endtask

   task automatic test_wrap();
      exp_t e;
      logic [37:0] obs;
      drv(0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 1, pk(32'h0, 1, 1, 0, 1, 1), MA, "pc_wrap");
      @(negedge clk);
      e   = sb.pop_front();
      obs = {pc_next, pc_le, ifid_le, ifid_flush, fetch_valid, state};
      total++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", e.name, obs & e.mask, e.exp & e.mask);
      end else $display("ok %s: outputs=%h", e.name, obs);
   endtask

   task automatic test_reset_mid_wait();
      exp_t e;
      logic [37:0] obs;
      for (int i = 0; i < 8; i++) begin
         case (i)
            0: drv(0, 32'h10, 1, 32'h700, 0, 0, 0, 0, pk(32'h700, 0, 1, 1, 0, 1), MA, "branch_mem_busy");
            1: drv(0, 32'h10, 0, 0, 0, 0, 0, 0, pk(32'h0, 0, 1, 1, 0, 2), MN, "wait_pending");
            2: begin
               // Reset while waiting with a fresh redirect; outputs not checked here.
               @(posedge clk);
               #1;
               set_in(1, 32'h10, 1, 32'h900, 0, 0, 0, 0);
            end
            3, 4: drv(0, 32'h0, 1, 32'hABC, 1, 32'hDEF, 1, 1, pk(32'h0, 1, 0, 1, 0, 0), MA, "reboot_ignores_inputs");
            5: drv(0, 32'h0, 0, 0, 0, 0, 0, 0, pk(32'h0, 0, 1, 1, 0, 1), MN, "run_mem_busy");
            6: drv(0, 32'h0, 0, 0, 0, 0, 0, 1, pk(32'h4, 1, 1, 0, 1, 2), MA, "pend_was_cleared");
            default: drv(0, 32'h4, 0, 0, 0, 0, 0, 1, pk(32'h8, 1, 1, 0, 1, 1), MA, "seq_after_reboot");
         endcase
         @(negedge clk);
         if (i != 2) begin
            e   = sb.pop_front();
            obs = {pc_next, pc_le, ifid_le, ifid_flush, fetch_valid, state};
            total++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
               bad++;
               $display("FAIL %s cyc%0d: got=%h want=%h", e.name, i, obs & e.mask, e.exp & e.mask);
            end else $display("ok %s cyc%0d: outputs=%h", e.name, i, obs);
         end
      end
   endtask

   initial begin
      set_in(1, 0, 0, 0, 0, 0, 0, 1);
      test_reset();
      test_load_use();
      test_redirect_priority();
      test_wait_branch();
      test_wait_overwrite();
      test_wrap();
      test_reset_mid_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Controller that sequences the PC register and the IF/ID pipeline register in the RISC-V pipeline. Each cycle it generates the PC load enable, the next-PC value, and the IF/ID enable and flush. It arbitrates between sequential fetch, branch/jump redirects, load-use stalls and instruction-memory wait states, and holds fetch for a fixed number of cycles after reset. Sits between hazard unit, branch/jump resolution logic, instruction memory and the PC register input/LE.

Parameters:
XLEN, 32, datapath/PC width
RESET_VECTOR, 32'h0000_0000, first fetch address after boot
BOOT_CYCLES, 2, cycles fetch is held after Reset deasserts (>=1)

Ports:
clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high reset
pc_cur  in  XLEN  current PC register output
branch_taken  in  1  EX-stage conditional branch resolved taken
branch_target  in  XLEN  EX-stage branch target
jump  in  1  ID-stage JAL/JALR redirect
jump_target  in  XLEN  ID-stage jump target
load_use_stall  in  1  hazard unit stall request
imem_ready  in  1  instruction memory has data for pc_cur this cycle
pc_next  out  XLEN  value for PC register input
pc_le  out  1  PC register load enable
ifid_le  out  1  IF/ID register load enable
ifid_flush  out  1  IF/ID bubble insert
fetch_valid  out  1  instruction presented to IF/ID this cycle is valid
state  out  2  FSM state (debug): 0 BOOT, 1 RUN, 2 WAIT_MEM

Behaviour:
- Single clk domain; all state updates on rising edge; Reset synchronous, active-high, highest priority.
- Registered state: FSM state, boot counter, pend (1 bit), pend_target (XLEN). Outputs are combinational from registered state plus current inputs.
- Reset: state=BOOT, counter=0, pend=0, pend_target=0. While in BOOT: pc_le=1 with pc_next=RESET_VECTOR, ifid_le=0, ifid_flush=1, fetch_valid=0.
- BOOT: counter increments each cycle; at counter==BOOT_CYCLES-1 -> RUN. All redirect/stall inputs are ignored.
- Redirect priority in RUN/WAIT_MEM: branch_taken > jump (EX is older than ID) > pend > load_use_stall > imem wait > sequential.
- RUN, branch_taken or jump: pc_next=target, ifid_flush=1, fetch_valid=0, ifid_le=1. If imem_ready=1: pc_le=1, stay RUN. If imem_ready=0: pc_le=0, latch pend=1 and pend_target=target, go WAIT_MEM.
- RUN, load_use_stall (no redirect): pc_le=0, ifid_le=0, ifid_flush=0, fetch_valid=0; stay RUN.
- RUN, imem_ready=0 (no redirect/stall): pc_le=0, ifid_le=1, ifid_flush=1 (bubble), fetch_valid=0; go WAIT_MEM.
- RUN, normal: pc_next=pc_cur+4 modulo 2^XLEN (32'hFFFF_FFFC wraps to 0), pc_le=1, ifid_le=1, fetch_valid=1.
- WAIT_MEM: bubble each cycle (ifid_flush=1, pc_le=0). A new branch_taken/jump overwrites pend_target and sets pend=1. On imem_ready=1: if pend, then pc_next=pend_target, pc_le=1, ifid_flush=1 (drop wrong-path instruction), clear pend; else apply normal RUN rules (load_use_stall honoured). Return to RUN in both cases.
- Redirect in the same cycle as load_use_stall: redirect wins; the stalled instruction is on the wrong path.
- Reset asserted mid-WAIT_MEM or with pend set: pend cleared, target discarded, BOOT restarts.
- No X on outputs after the first Reset edge.

Decomposition:
- Shared package pc_seq_pkg: state encoding constants (BOOT=2'd0, RUN=2'd1, WAIT_MEM=2'd2), INSTR_BYTES=4, default RESET_VECTOR.
- One natural sub-module: pc_redirect_latch (pend flag plus pend_target register with set/clear/overwrite priority).
- FSM and output decode stay in pc_sequencer.

Test Plan:
- Reset 3 cycles, then release with BOOT_CYCLES=2 and imem_ready=1 -> 2 cycles of fetch_valid=0 and pc_next=0; then pc_next=4, 8, 12 with pc_le=1 and fetch_valid=1.
- pc_cur=32'h40, load_use_stall=1 for 2 cycles -> pc_le=0, ifid_le=0, ifid_flush=0; after release, pc_next=32'h44.
- Same cycle: branch_taken (target 32'h100), jump (target 32'h200) and load_use_stall -> pc_next=32'h100, pc_le=1, ifid_flush=1.
- imem_ready=0 and branch_taken (target 32'h80), then 3 wait cycles, then imem_ready=1 -> pc_le=0 and state=2 while waiting; on ready, pc_next=32'h80, pc_le=1, ifid_flush=1, state back to 1.
- In WAIT_MEM: jump to 32'h300, then branch to 32'h500 on a later cycle, then ready -> pc_next=32'h500.
- pc_cur=32'hFFFF_FFFC in normal RUN -> pc_next=32'h0; Reset asserted during WAIT_MEM with pend set -> state=0 and pc_next=RESET_VECTOR next cycle.
